// File: rtl/mc_control_unit.sv
// mc_control_unit: multicycle control FSM for the MIPS-subset datapath.
// Outputs are registered from the next-state decode, so each control word is
// valid during the cycle its state is current.
module mc_control_unit #(
  parameter int MD_CYCLES = 33,
  parameter int MEM_WAIT  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opCode,
  input  logic [5:0] funct,
  input  logic       eqf,
  input  logic       gtf,
  input  logic       ov,
  input  logic       div0,
  output logic       MemCtrl,
  output logic       PCCtrl,
  output logic       MDCtrl,
  output logic       SECtrl,
  output logic       ShiftSrc,
  output logic       ShiftAmt,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       ALUOutCtrl,
  output logic       EPCCtrl,
  output logic       HILOWrite,
  output logic       start,
  output logic [1:0] IorD,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] RegDst,
  output logic [1:0] LSCtrl,
  output logic [1:0] SSCtrl,
  output logic [1:0] ExcptCtrl,
  output logic [2:0] ShiftCtrl,
  output logic [2:0] PCSrc,
  output logic [2:0] ALUCtrl,
  output logic [3:0] DataSrc,
  output logic [5:0] state
);

  typedef enum logic [5:0] {
    S_RESET    = 6'd0,  S_FETCH   = 6'd1,  S_F_WAIT   = 6'd2,  S_IR_LD  = 6'd3,
    S_DECODE   = 6'd4,  S_R_EX    = 6'd5,  S_R_WB     = 6'd6,  S_ADDI   = 6'd7,
    S_I_WB     = 6'd8,  S_ADDR    = 6'd9,  S_M_RD     = 6'd10, S_M_WAIT = 6'd11,
    S_LW_WB    = 6'd12, S_SW_WR   = 6'd13, S_BR       = 6'd14, S_LUI    = 6'd15,
    S_J        = 6'd16, S_JAL_A   = 6'd17, S_JAL      = 6'd18, S_JR     = 6'd19,
    S_MD_START = 6'd20, S_MD_WAIT = 6'd21, S_MF       = 6'd22, S_EXC    = 6'd23,
    S_E_RD     = 6'd24, S_E_WAIT  = 6'd25, S_E_JMP    = 6'd26
  } state_t;

  // One counter serves both the memory waits and the mult/div wait.
  localparam int CNT_MAX = (MD_CYCLES > MEM_WAIT + 1) ? MD_CYCLES : MEM_WAIT + 1;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] MD_LAST = CW'(MD_CYCLES - 1);
  localparam logic [CW-1:0] FW_LAST = CW'(MEM_WAIT - 1);
  localparam logic [CW-1:0] MW_LAST = CW'(MEM_WAIT);

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [1:0]      cause_reg, cause_next;
  logic            md_div_reg, md_div_next;
  logic            pcctrl_reg;
  logic [2:0]      pcsrc_reg;

  logic            memctrl_next, pcctrl_next, mdctrl_next, sectrl_next;
  logic            irwrite_next, regwrite_next, aluoutctrl_next, epcctrl_next;
  logic            hilowrite_next, start_next;
  logic [1:0]      iord_next, alusrca_next, alusrcb_next, regdst_next;
  logic [1:0]      lsctrl_next, ssctrl_next, excptctrl_next;
  logic [2:0]      pcsrc_next, aluctrl_next;
  logic [3:0]      datasrc_next;
  logic            br_take;
  logic            unused_flags;

  assign unused_flags = gtf;
  assign state        = state_reg;

  // The branch decision needs the compare result produced during BR itself,
  // so the PC-write qualification is the one term taken from live inputs.
  assign br_take = (state_reg == S_BR) &&
                   (((opCode == 6'h04) && eqf) || ((opCode == 6'h05) && !eqf));
  assign PCCtrl  = pcctrl_reg | br_take;
  assign PCSrc   = br_take ? 3'd1 : pcsrc_reg;

  // State, counter, cause and registered control word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= S_RESET;
      cnt_reg    <= '0;
      cause_reg  <= 2'd0;
      md_div_reg <= 1'b0;
      MemCtrl    <= 1'b0;
      pcctrl_reg <= 1'b0;
      MDCtrl     <= 1'b0;
      SECtrl     <= 1'b0;
      ShiftSrc   <= 1'b0;
      ShiftAmt   <= 1'b0;
      IRWrite    <= 1'b0;
      RegWrite   <= 1'b0;
      ALUOutCtrl <= 1'b0;
      EPCCtrl    <= 1'b0;
      HILOWrite  <= 1'b0;
      start      <= 1'b0;
      IorD       <= 2'd0;
      ALUSrcA    <= 2'd0;
      ALUSrcB    <= 2'd0;
      RegDst     <= 2'd0;
      LSCtrl     <= 2'd0;
      SSCtrl     <= 2'd0;
      ExcptCtrl  <= 2'd0;
      ShiftCtrl  <= 3'd0;
      pcsrc_reg  <= 3'd0;
      ALUCtrl    <= 3'd0;
      DataSrc    <= 4'd0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      cause_reg  <= cause_next;
      md_div_reg <= md_div_next;
      MemCtrl    <= memctrl_next;
      pcctrl_reg <= pcctrl_next;
      MDCtrl     <= mdctrl_next;
      SECtrl     <= sectrl_next;
      ShiftSrc   <= 1'b0;
      ShiftAmt   <= 1'b0;
      IRWrite    <= irwrite_next;
      RegWrite   <= regwrite_next;
      ALUOutCtrl <= aluoutctrl_next;
      EPCCtrl    <= epcctrl_next;
      HILOWrite  <= hilowrite_next;
      start      <= start_next;
      IorD       <= iord_next;
      ALUSrcA    <= alusrca_next;
      ALUSrcB    <= alusrcb_next;
      RegDst     <= regdst_next;
      LSCtrl     <= lsctrl_next;
      SSCtrl     <= ssctrl_next;
      ExcptCtrl  <= excptctrl_next;
      ShiftCtrl  <= 3'd0;
      pcsrc_reg  <= pcsrc_next;
      ALUCtrl    <= aluctrl_next;
      DataSrc    <= datasrc_next;
    end
  end

  // Next-state selection followed by the control word of the next state.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    cause_next      = cause_reg;
    md_div_next     = md_div_reg;
    memctrl_next    = 1'b0;
    pcctrl_next     = 1'b0;
    mdctrl_next     = 1'b0;
    sectrl_next     = 1'b0;
    irwrite_next    = 1'b0;
    regwrite_next   = 1'b0;
    aluoutctrl_next = 1'b0;
    epcctrl_next    = 1'b0;
    hilowrite_next  = 1'b0;
    start_next      = 1'b0;
    iord_next       = 2'd0;
    alusrca_next    = 2'd0;
    alusrcb_next    = 2'd0;
    regdst_next     = 2'd0;
    lsctrl_next     = 2'd0;
    ssctrl_next     = 2'd0;
    excptctrl_next  = 2'd0;
    pcsrc_next      = 3'd0;
    aluctrl_next    = 3'd0;
    datasrc_next    = 4'd0;

    case (state_reg)
      S_RESET: state_next = S_FETCH;
      S_FETCH: begin
        cnt_next = '0;
        if (MEM_WAIT == 0) state_next = S_IR_LD;
        else               state_next = S_F_WAIT;
      end
      S_F_WAIT: begin
        if (cnt_reg == FW_LAST) state_next = S_IR_LD;
        else                    cnt_next   = cnt_reg + CW'(1);
      end
      S_IR_LD: state_next = S_DECODE;
      S_DECODE: begin
        md_div_next = (funct == 6'h1A);
        cause_next  = 2'd0;
        state_next  = S_EXC;
        case (opCode)
          6'h00: begin
            case (funct)
              6'h20, 6'h22, 6'h24: state_next = S_R_EX;
              6'h18, 6'h1A:        state_next = S_MD_START;
              6'h10, 6'h12:        state_next = S_MF;
              6'h08:               state_next = S_JR;
              default:             state_next = S_EXC;
            endcase
          end
          6'h08:        state_next = S_ADDI;
          6'h23, 6'h2B: state_next = S_ADDR;
          6'h04, 6'h05: state_next = S_BR;
          6'h0F:        state_next = S_LUI;
          6'h02:        state_next = S_J;
          6'h03:        state_next = S_JAL_A;
          default:      state_next = S_EXC;
        endcase
      end
      S_R_EX: begin
        if (ov && (funct != 6'h24)) begin
          state_next = S_EXC;
          cause_next = 2'd1;
        end else begin
          state_next = S_R_WB;
        end
      end
      S_ADDI: begin
        if (ov) begin
          state_next = S_EXC;
          cause_next = 2'd1;
        end else begin
          state_next = S_I_WB;
        end
      end
      S_ADDR: state_next = S_M_RD;
      S_M_RD: begin
        state_next = S_M_WAIT;
        cnt_next   = '0;
      end
      S_M_WAIT: begin
        if (cnt_reg == MW_LAST) state_next = (opCode == 6'h2B) ? S_SW_WR : S_LW_WB;
        else                    cnt_next   = cnt_reg + CW'(1);
      end
      S_JAL_A: state_next = S_JAL;
      S_MD_START: begin
        state_next = S_MD_WAIT;
        cnt_next   = '0;
      end
      S_MD_WAIT: begin
        if (md_div_reg && div0 && (cnt_reg == '0)) begin
          state_next = S_EXC;
          cause_next = 2'd2;
        end else if (cnt_reg == MD_LAST) begin
          state_next = S_FETCH;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      S_EXC: state_next = S_E_RD;
      S_E_RD: begin
        state_next = S_E_WAIT;
        cnt_next   = '0;
      end
      S_E_WAIT: begin
        if (cnt_reg == MW_LAST) state_next = S_E_JMP;
        else                    cnt_next   = cnt_reg + CW'(1);
      end
      S_R_WB, S_I_WB, S_LW_WB, S_SW_WR, S_BR, S_LUI, S_J, S_JAL, S_JR, S_MF, S_E_JMP:
        state_next = S_FETCH;
      default: state_next = S_RESET;
    endcase

    case (state_next)
      S_FETCH: begin
        alusrcb_next = 2'd1;
        aluctrl_next = 3'b001;
        pcctrl_next  = 1'b1;
      end
      S_IR_LD: irwrite_next = 1'b1;
      S_DECODE: begin
        alusrcb_next    = 2'd3;
        aluctrl_next    = 3'b001;
        aluoutctrl_next = 1'b1;
      end
      S_R_EX: begin
        alusrca_next    = 2'd1;
        aluoutctrl_next = 1'b1;
        if (funct == 6'h22)      aluctrl_next = 3'b010;
        else if (funct == 6'h24) aluctrl_next = 3'b011;
        else                     aluctrl_next = 3'b001;
      end
      S_R_WB: begin
        regdst_next   = 2'd1;
        regwrite_next = 1'b1;
      end
      S_ADDI, S_ADDR: begin
        alusrca_next    = 2'd1;
        alusrcb_next    = 2'd2;
        sectrl_next     = 1'b1;
        aluctrl_next    = 3'b001;
        aluoutctrl_next = 1'b1;
      end
      S_I_WB: regwrite_next = 1'b1;
      S_M_RD: iord_next = 2'd2;
      S_LW_WB: begin
        lsctrl_next   = 2'd1;
        datasrc_next  = 4'd1;
        regwrite_next = 1'b1;
      end
      S_SW_WR: begin
        ssctrl_next  = 2'd1;
        iord_next    = 2'd2;
        memctrl_next = 1'b1;
      end
      S_BR: begin
        alusrca_next = 2'd1;
        aluctrl_next = 3'b010;
      end
      S_LUI: begin
        datasrc_next  = 4'd6;
        regwrite_next = 1'b1;
      end
      S_J: begin
        pcsrc_next  = 3'd2;
        pcctrl_next = 1'b1;
      end
      S_JAL_A: aluoutctrl_next = 1'b1;
      S_JAL: begin
        regdst_next   = 2'd3;
        regwrite_next = 1'b1;
        pcsrc_next    = 3'd2;
        pcctrl_next   = 1'b1;
      end
      S_JR: begin
        alusrca_next = 2'd1;
        pcctrl_next  = 1'b1;
      end
      S_MD_START: begin
        start_next  = 1'b1;
        mdctrl_next = md_div_next;
      end
      S_MD_WAIT: hilowrite_next = (cnt_next == MD_LAST);
      S_MF: begin
        datasrc_next  = (funct == 6'h10) ? 4'd2 : 4'd3;
        regdst_next   = 2'd1;
        regwrite_next = 1'b1;
      end
      S_EXC: begin
        alusrcb_next = 2'd1;
        aluctrl_next = 3'b010;
        epcctrl_next = 1'b1;
      end
      S_E_RD: begin
        iord_next      = 2'd3;
        excptctrl_next = cause_next;
      end
      S_E_JMP: begin
        lsctrl_next = 2'd1;
        pcsrc_next  = 3'd3;
        pcctrl_next = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: drives instruction opcodes/flags and compares the
// control word every cycle against a per-instruction step-list model.
module tb_mc_control_unit;

  localparam int MDC = 33;
  localparam int MW  = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opCode, funct;
  logic       eqf, gtf, ov, div0;
  logic       MemCtrl, PCCtrl, MDCtrl, SECtrl, ShiftSrc, ShiftAmt, IRWrite, RegWrite;
  logic       ALUOutCtrl, EPCCtrl, HILOWrite, start;
  logic [1:0] IorD, ALUSrcA, ALUSrcB, RegDst, LSCtrl, SSCtrl, ExcptCtrl;
  logic [2:0] ShiftCtrl, PCSrc, ALUCtrl;
  logic [3:0] DataSrc;
  logic [5:0] state;

  mc_control_unit #(.MD_CYCLES(MDC), .MEM_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .opCode(opCode), .funct(funct),
    .eqf(eqf), .gtf(gtf), .ov(ov), .div0(div0),
    .MemCtrl(MemCtrl), .PCCtrl(PCCtrl), .MDCtrl(MDCtrl), .SECtrl(SECtrl),
    .ShiftSrc(ShiftSrc), .ShiftAmt(ShiftAmt), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ALUOutCtrl(ALUOutCtrl), .EPCCtrl(EPCCtrl), .HILOWrite(HILOWrite), .start(start),
    .IorD(IorD), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegDst(RegDst),
    .LSCtrl(LSCtrl), .SSCtrl(SSCtrl), .ExcptCtrl(ExcptCtrl), .ShiftCtrl(ShiftCtrl),
    .PCSrc(PCSrc), .ALUCtrl(ALUCtrl), .DataSrc(DataSrc), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem, pcc, md, se, ssrc, samt, irw, rw, aluout, epc, hilo, strt;
    logic [1:0] iord, srca, srcb, regdst, ls, ss, exc;
    logic [2:0] shctl, pcsrc, aluctl;
    logic [3:0] datasrc;
  } ctl_t;

  ctl_t obs;
  ctl_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always_comb begin
    obs = '0;
    obs.mem = MemCtrl;   obs.pcc = PCCtrl;       obs.md = MDCtrl;     obs.se = SECtrl;
    obs.ssrc = ShiftSrc; obs.samt = ShiftAmt;    obs.irw = IRWrite;   obs.rw = RegWrite;
    obs.aluout = ALUOutCtrl; obs.epc = EPCCtrl;  obs.hilo = HILOWrite; obs.strt = start;
    obs.iord = IorD;     obs.srca = ALUSrcA;     obs.srcb = ALUSrcB;  obs.regdst = RegDst;
    obs.ls = LSCtrl;     obs.ss = SSCtrl;        obs.exc = ExcptCtrl; obs.shctl = ShiftCtrl;
    obs.pcsrc = PCSrc;   obs.aluctl = ALUCtrl;   obs.datasrc = DataSrc;
  end

  // Exception entry: save EPC, read handler byte, wait, jump.
  task automatic push_exc(input logic [1:0] cause);
    ctl_t c;
    c = '0; c.srcb = 2'd1; c.aluctl = 3'b010; c.epc = 1'b1; exp_q.push_back(c);
    c = '0; c.iord = 2'd3; c.exc = cause; exp_q.push_back(c);
    repeat (MW + 1) begin c = '0; exp_q.push_back(c); end
    c = '0; c.ls = 2'd1; c.pcsrc = 3'd3; c.pcc = 1'b1; exp_q.push_back(c);
  endtask

  // Expected per-cycle control words for one instruction, FETCH onwards.
  task automatic build(input logic [5:0] op, input logic [5:0] fn,
                       input logic e, input logic o, input logic d);
    ctl_t c;
    logic done;
    exp_q.delete();
    c = '0; c.srcb = 2'd1; c.aluctl = 3'b001; c.pcc = 1'b1; exp_q.push_back(c);
    repeat (MW) begin c = '0; exp_q.push_back(c); end
    c = '0; c.irw = 1'b1; exp_q.push_back(c);
    c = '0; c.srcb = 2'd3; c.aluctl = 3'b001; c.aluout = 1'b1; exp_q.push_back(c);
    if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24)) begin
      c = '0; c.srca = 2'd1; c.aluout = 1'b1;
      c.aluctl = (fn == 6'h22) ? 3'b010 : (fn == 6'h24) ? 3'b011 : 3'b001;
      exp_q.push_back(c);
      if (o && fn != 6'h24) push_exc(2'd1);
      else begin c = '0; c.regdst = 2'd1; c.rw = 1'b1; exp_q.push_back(c); end
    end else if (op == 6'h00 && (fn == 6'h18 || fn == 6'h1A)) begin
      c = '0; c.strt = 1'b1; c.md = (fn == 6'h1A); exp_q.push_back(c);
      done = 1'b0;
      for (int k = 0; k < MDC && !done; k++) begin
        c = '0; c.hilo = (k == MDC - 1); exp_q.push_back(c);
        if (k == 0 && fn == 6'h1A && d) begin push_exc(2'd2); done = 1'b1; end
      end
    end else if (op == 6'h00 && (fn == 6'h10 || fn == 6'h12)) begin
      c = '0; c.datasrc = (fn == 6'h10) ? 4'd2 : 4'd3; c.regdst = 2'd1; c.rw = 1'b1;
      exp_q.push_back(c);
    end else if (op == 6'h00 && fn == 6'h08) begin
      c = '0; c.srca = 2'd1; c.pcc = 1'b1; exp_q.push_back(c);
    end else if (op == 6'h08) begin
      c = '0; c.srca = 2'd1; c.srcb = 2'd2; c.se = 1'b1; c.aluctl = 3'b001; c.aluout = 1'b1;
      exp_q.push_back(c);
      if (o) push_exc(2'd1);
      else begin c = '0; c.rw = 1'b1; exp_q.push_back(c); end
    end else if (op == 6'h23 || op == 6'h2B) begin
      c = '0; c.srca = 2'd1; c.srcb = 2'd2; c.se = 1'b1; c.aluctl = 3'b001; c.aluout = 1'b1;
      exp_q.push_back(c);
      c = '0; c.iord = 2'd2; exp_q.push_back(c);
      repeat (MW + 1) begin c = '0; exp_q.push_back(c); end
      c = '0;
      if (op == 6'h23) begin c.ls = 2'd1; c.datasrc = 4'd1; c.rw = 1'b1; end
      else begin c.ss = 2'd1; c.iord = 2'd2; c.mem = 1'b1; end
      exp_q.push_back(c);
    end else if (op == 6'h04 || op == 6'h05) begin
      c = '0; c.srca = 2'd1; c.aluctl = 3'b010;
      if ((op == 6'h04) ? e : !e) begin c.pcsrc = 3'd1; c.pcc = 1'b1; end
      exp_q.push_back(c);
    end else if (op == 6'h0F) begin
      c = '0; c.datasrc = 4'd6; c.rw = 1'b1; exp_q.push_back(c);
    end else if (op == 6'h02) begin
      c = '0; c.pcsrc = 3'd2; c.pcc = 1'b1; exp_q.push_back(c);
    end else if (op == 6'h03) begin
      c = '0; c.aluout = 1'b1; exp_q.push_back(c);
      c = '0; c.regdst = 2'd3; c.rw = 1'b1; c.pcsrc = 3'd2; c.pcc = 1'b1; exp_q.push_back(c);
    end else begin
      push_exc(2'd0);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                       input logic e, input logic o, input logic d);
    opCode = op; funct = fn; eqf = e; ov = o; div0 = d;
    gtf = 1'($urandom_range(0, 1));
    build(op, fn, e, o, d);
    $display("instr op=%h fn=%h eqf=%0d ov=%0d div0=%0d cycles=%0d", op, fn, e, o, d, exp_q.size());
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(6'h00, 6'h18, 1'b0, 1'b0, 1'b0);
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (state !== 6'd0 || obs !== '0) begin
        errors++; $display("FAIL reset_init state=%0d ctl=%h want 0/0", state, obs);
      end
    end
    reset = 1'b0;
    // Run a mult part-way into its wait, then reset mid-wait.
    for (int i = 0; i < 4 + MW + 6; i++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++; $display("FAIL reset_pre cyc=%0d got %h want %h", i, obs, exp_q[i]);
      end
    end
    reset = 1'b1;
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (state !== 6'd0 || obs !== '0 || start !== 1'b0) begin
        errors++; $display("FAIL reset_mid state=%0d ctl=%h start=%0d want 0", state, obs, start);
      end
    end
    reset = 1'b0;
    drive(6'h00, 6'h20, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++; $display("FAIL reset_release cyc=%0d got %h want %h", i, obs, exp_q[i]);
      end
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fns [3];
    fns = '{6'h20, 6'h22, 6'h24};
    for (int n = 0; n < 9; n++) begin
      drive(6'h00, fns[n % 3], 1'($urandom_range(0, 1)), (n >= 3) ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0);
      if (n == 8) drive(6'h00, 6'h20, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < exp_q.size(); i++) begin
        @(posedge clk); @(negedge clk);
        checks++;
        if (obs !== exp_q[i]) begin
          errors++; $display("FAIL rtype fn=%h cyc=%0d got %h want %h", funct, i, obs, exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_mem_branch();
    logic [5:0] ops [6];
    logic       eqs [6];
    int         mem_wr;
    ops = '{6'h23, 6'h2B, 6'h04, 6'h04, 6'h05, 6'h05};
    eqs = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int n = 0; n < 6; n++) begin
      drive(ops[n], 6'($urandom_range(0, 63)), eqs[n], 1'b0, 1'b0);
      mem_wr = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
        @(posedge clk); @(negedge clk);
        if (MemCtrl === 1'b1 && SSCtrl === 2'd1 && IorD === 2'd2) mem_wr++;
        checks++;
        if (obs !== exp_q[i]) begin
          errors++; $display("FAIL membr op=%h cyc=%0d got %h want %h", opCode, i, obs, exp_q[i]);
        end
      end
      checks++;
      if (mem_wr !== ((ops[n] == 6'h2B) ? 1 : 0)) begin
        errors++; $display("FAIL store_count op=%h got %0d", ops[n], mem_wr);
      end
    end
  endtask

  task automatic test_jumps_misc();
    logic [11:0] ins [8];
    ins = '{{6'h0F, 6'h00}, {6'h02, 6'h15}, {6'h03, 6'h01}, {6'h00, 6'h08},
            {6'h00, 6'h10}, {6'h00, 6'h12}, {6'h3F, 6'h00}, {6'h00, 6'h3F}};
    for (int n = 0; n < 8; n++) begin
      drive(ins[n][11:6], ins[n][5:0], 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < exp_q.size(); i++) begin
        @(posedge clk); @(negedge clk);
        checks++;
        if (obs !== exp_q[i]) begin
          errors++; $display("FAIL misc op=%h fn=%h cyc=%0d got %h want %h", opCode, funct, i, obs, exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_muldiv();
    logic [5:0] fns [3];
    logic       d0s [3];
    int start_at, hilo_at, hilo_cnt, start_cnt;
    fns = '{6'h18, 6'h1A, 6'h1A};
    d0s = '{1'b1, 1'b0, 1'b1};
    for (int n = 0; n < 3; n++) begin
      drive(6'h00, fns[n], 1'b0, 1'b0, d0s[n]);
      start_at = -1; hilo_at = -1; hilo_cnt = 0; start_cnt = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
        @(posedge clk); @(negedge clk);
        if (start === 1'b1) begin start_cnt++; start_at = i; end
        if (HILOWrite === 1'b1) begin hilo_cnt++; hilo_at = i; end
        checks++;
        if (obs !== exp_q[i]) begin
          errors++; $display("FAIL muldiv fn=%h cyc=%0d got %h want %h", funct, i, obs, exp_q[i]);
        end
      end
      checks++;
      if (start_cnt !== 1) begin
        errors++; $display("FAIL start_pulses fn=%h got %0d want 1", fns[n], start_cnt);
      end
      checks++;
      if (fns[n] == 6'h1A && d0s[n]) begin
        if (hilo_cnt !== 0) begin
          errors++; $display("FAIL div0_hilo got %0d pulses want 0", hilo_cnt);
        end
      end else if (hilo_cnt !== 1 || hilo_at - start_at !== MDC) begin
        errors++; $display("FAIL hilo_timing cnt=%0d delay=%0d want 1/%0d", hilo_cnt, hilo_at - start_at, MDC);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] tbl [16];
    logic [11:0] pick;
    tbl = '{{6'h00, 6'h20}, {6'h00, 6'h22}, {6'h00, 6'h24}, {6'h00, 6'h18},
            {6'h00, 6'h1A}, {6'h00, 6'h10}, {6'h00, 6'h12}, {6'h00, 6'h08},
            {6'h08, 6'h00}, {6'h23, 6'h00}, {6'h2B, 6'h00}, {6'h04, 6'h00},
            {6'h05, 6'h00}, {6'h0F, 6'h00}, {6'h02, 6'h00}, {6'h03, 6'h00}};
    for (int n = 0; n < 40; n++) begin
      pick = tbl[$urandom_range(0, 15)];
      if ($urandom_range(0, 7) == 0) pick = 12'($urandom_range(0, 4095));
      else if (pick[11:6] != 6'h00) pick[5:0] = 6'($urandom_range(0, 63));
      drive(pick[11:6], pick[5:0], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
      for (int i = 0; i < exp_q.size(); i++) begin
        @(posedge clk); @(negedge clk);
        checks++;
        if (obs !== exp_q[i]) begin
          errors++; $display("FAIL random op=%h fn=%h cyc=%0d got %h want %h", opCode, funct, i, obs, exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; opCode = '0; funct = '0; eqf = 1'b0; gtf = 1'b0; ov = 1'b0; div0 = 1'b0;
    @(negedge clk);
    test_reset();
    test_rtype();
    test_mem_branch();
    test_jumps_misc();
    test_muldiv();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
Moore-style multicycle control FSM that sequences the MIPS-subset datapath: fetch, decode, execute, memory, write-back, multiply/divide wait and exception entry. It consumes opCode/funct/flags from the datapath and drives every datapath control input. It is instantiated beside the datapath in the top level, with clock and reset shared.

Parameters:
MD_CYCLES, 33, cycles from DIVMULT start until HI/LO are valid
MEM_WAIT, 1, wait cycles after a memory read before data is on wMemOut/MDR

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
opCode  in  6  IR[31:26]
funct  in  6  IR[5:0]
eqf, gtf, ov, div0  in  1 each  ALU/DIVMULT flags
MemCtrl, PCCtrl, MDCtrl, SECtrl, ShiftSrc, ShiftAmt, IRWrite, RegWrite, ALUOutCtrl, EPCCtrl, HILOWrite, start  out  1 each  datapath controls
IorD, ALUSrcA, ALUSrcB, RegDst, LSCtrl, SSCtrl, ExcptCtrl  out  2 each
ShiftCtrl, PCSrc, ALUCtrl  out  3 each
DataSrc  out  4
state  out  6  current state code, for debug

Behaviour:
- One clock; reset is synchronous and active-high. Reset enters RESET; all outputs 0; state=0.
- Mux encodings: IorD 0=PC,1=ALUResult,2=ALUOut,3=exception address; ALUSrcA 0=PC,1=A,2=LS; ALUSrcB 0=B,1=4,2=SE16,3=SE16<<2; RegDst 0=rt,1=rd,2=30,3=31; PCSrc 0=ALUResult,1=ALUOut,2=jump target,3=LS,4=EPC; DataSrc 0=ALUOut,1=LS,2=HI,3=LO,6=SL16; ExcptCtrl 0=253 (bad opcode),1=254 (overflow),2=255 (div0); ALUCtrl 000=load A,001=add,010=sub,011=and; LSCtrl/SSCtrl 1=word; MDCtrl 0=mult,1=div.
- Every output is 0 in a state unless listed for that state. Outputs are registered from next-state, so they are valid in the cycle the state is current.
- RESET -> FETCH.
- FETCH: IorD=0, MemCtrl=0 (read); PC<=PC+4 (ALUSrcA=0, ALUSrcB=1, ALUCtrl=001, PCSrc=0, PCCtrl=1). Then MEM_WAIT cycles in F_WAIT, then IR_LD (IRWrite=1).
- DECODE: ALUOut<=PC+(SE16<<2) (ALUSrcB=3, add, ALUOutCtrl=1). Dispatch:
  - opCode 0 with funct 0x20/0x22/0x24 -> R_EX
  - 0x18/0x1A -> MD_START; 0x10/0x12 -> MF; 0x08 -> JR
  - opCode 0x08 -> ADDI; 0x23/0x2B -> ADDR; 0x04/0x05 -> BR; 0x0F -> LUI; 0x02 -> J; 0x03 -> JAL
  - anything else -> EXC with cause 0
- R_EX: ALUSrcA=1, ALUSrcB=0, ALUCtrl per funct, ALUOutCtrl=1. If ov and add/sub -> EXC cause 1; else R_WB (RegDst=1, DataSrc=0, RegWrite=1) -> FETCH.
- ADDI: as R_EX but ALUSrcB=2, SECtrl=1. Overflow -> EXC cause 1; else I_WB (RegDst=0) -> FETCH.
- ADDR: ALUOut<=A+SE16. lw: M_RD (IorD=2, read) -> MEM_WAIT+1 wait cycles -> LW_WB (LSCtrl=1, DataSrc=1, RegDst=0, RegWrite=1). sw: M_RD first (for MDR), wait, then SW_WR (SSCtrl=1, IorD=2, MemCtrl=1) -> FETCH.
- BR: ALUSrcA=1, ALUSrcB=0, sub. If (beq and eqf) or (bne and !eqf): PCSrc=1, PCCtrl=1. -> FETCH.
- LUI: DataSrc=6, RegDst=0, RegWrite=1. J: PCSrc=2, PCCtrl=1. JAL: RegDst=3, DataSrc=0 (ALUOut holds PC via ALUSrcA=0, ALUCtrl=000 in prior cycle JAL_A), then PCSrc=2. JR: ALUSrcA=1, ALUCtrl=000, PCSrc=0, PCCtrl=1.
- MD_START: start=1 for exactly one cycle; MDCtrl per funct; counter<=0 -> MD_WAIT.
- MD_WAIT: counter increments. If div and div0 seen in the first wait cycle -> EXC cause 2, with no HILOWrite. At counter==MD_CYCLES-1: HILOWrite=1 -> FETCH.
- MF: DataSrc=2 or 3, RegDst=1, RegWrite=1.
- EXC (cause latched in a 2-bit register):
  - EPC<=PC-4 (ALUSrcA=0, ALUSrcB=1, sub, EPCCtrl=1).
  - E_RD: IorD=3, ExcptCtrl=cause, read; wait MEM_WAIT+1.
  - E_JMP: LSCtrl=1, PCSrc=3, PCCtrl=1 -> FETCH. Byte-sized handler address from mem[253..255].
- Reset asserted in any state, including MD_WAIT, returns to RESET next edge. The counter clears and start is deasserted.

Test Plan:
- reset high 2 cycles mid-MD_WAIT -> state=0, all outputs 0, start=0; release -> FETCH with IorD=0, PCCtrl=1, ALUSrcB=1.
- add $3,$1,$2 (opCode 0, funct 0x20) -> FETCH, F_WAIT, IR_LD, DECODE, R_EX, R_WB; RegWrite=1, RegDst=1 only in R_WB; 6 cycles total.
- lw with MEM_WAIT=1 -> LW_WB has LSCtrl=1, DataSrc=1, RegWrite=1. sw -> exactly one cycle with MemCtrl=1, SSCtrl=1, IorD=2.
- beq with eqf=1 -> PCCtrl=1, PCSrc=1 in BR; with eqf=0 -> PCCtrl=0; bne inverts.
- div with div0=1 -> start pulses 1 cycle, then EXC cause 2: EPCCtrl=1, then IorD=3, ExcptCtrl=2, then PCSrc=3; HILOWrite never 1.
- mult, MD_CYCLES=33 -> HILOWrite=1 exactly once, 33 cycles after the start pulse. Opcode 0x3F -> ExcptCtrl=0. add with ov=1 -> ExcptCtrl=1, no RegWrite.
